rob_multi_commit: RTL and testbench

- Parametrised reorder buffer, successor of the single-commit ROB. Sits between dispatcher, RS/LSB writeback buses, register file, LSB and predictor.
- Adds configurable depth, NUM_WB writeback channels, and dual in-order commit.
- Adds writeback-to-dispatch bypass, an exact occupancy count, a store-commit valid/ack handshake to the LSB, and JALR redirect.

---
 rtl/rob_multi_commit_if.sv | 64 ++++++
 rtl/rob_multi_commit.sv | 213 +++++++++++++++++++++
 tb/tb_rob_multi_commit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_multi_commit_if.sv
// rtl/rob_multi_commit_if.sv - reorder buffer bus: dispatch, writeback, operand query, commit, store, predictor, redirect
interface rob_multi_commit_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_WB = 2
);
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [ID_W-1:0]          alloc_id;
  logic [ADDR_W-1:0]        alloc_pc;
  logic [4:0]               alloc_rd;
  logic [1:0]               alloc_kind;
  logic                     alloc_pred_taken;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*ID_W-1:0]   wb_id;
  logic [NUM_WB*DATA_W-1:0] wb_value;
  logic [NUM_WB-1:0]        wb_taken;
  logic [NUM_WB*ADDR_W-1:0] wb_target;
  logic                     qj_dep;
  logic                     qk_dep;
  logic [ID_W-1:0]          qj_id;
  logic [ID_W-1:0]          qk_id;
  logic                     qj_ready;
  logic                     qk_ready;
  logic [DATA_W-1:0]        qj_value;
  logic [DATA_W-1:0]        qk_value;
  logic [1:0]               commit_valid;
  logic [9:0]               commit_rd;
  logic [2*DATA_W-1:0]      commit_value;
  logic [2*ID_W-1:0]        commit_id;
  logic                     store_commit_valid;
  logic [ID_W-1:0]          store_commit_id;
  logic                     store_commit_ack;
  logic                     bp_update_valid;
  logic [ADDR_W-1:0]        bp_update_pc;
  logic                     bp_update_taken;
  logic                     flush;
  logic [ADDR_W-1:0]        redirect_pc;
  logic [ID_W:0]            count;
  logic                     empty;

  modport master (
    output alloc_valid, alloc_pc, alloc_rd, alloc_kind, alloc_pred_taken,
    output wb_valid, wb_id, wb_value, wb_taken, wb_target,
    output qj_dep, qk_dep, qj_id, qk_id, store_commit_ack,
    input  alloc_ready, alloc_id, qj_ready, qk_ready, qj_value, qk_value,
    input  commit_valid, commit_rd, commit_value, commit_id,
    input  store_commit_valid, store_commit_id,
    input  bp_update_valid, bp_update_pc, bp_update_taken,
    input  flush, redirect_pc, count, empty
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_rd, alloc_kind, alloc_pred_taken,
    input  wb_valid, wb_id, wb_value, wb_taken, wb_target,
    input  qj_dep, qk_dep, qj_id, qk_id, store_commit_ack,
    output alloc_ready, alloc_id, qj_ready, qk_ready, qj_value, qk_value,
    output commit_valid, commit_rd, commit_value, commit_id,
    output store_commit_valid, store_commit_id,
    output bp_update_valid, bp_update_pc, bp_update_taken,
    output flush, redirect_pc, count, empty
  );
endinterface

// File: rtl/rob_multi_commit.sv
// rtl/rob_multi_commit.sv - parametrised reorder buffer with dual in-order commit
// Store handshake to the LSB, branch/JALR redirect and writeback-to-dispatch bypass.
module rob_multi_commit #(
  parameter int DEPTH  = 16,
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_WB = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  rob_multi_commit_if.slave  bus
);
  localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BR = 2'd2, K_JALR = 2'd3;

  logic [DEPTH-1:0]  ent_valid, ent_ready, ent_pred, ent_taken;
  logic [1:0]        ent_kind   [DEPTH];
  logic [4:0]        ent_rd     [DEPTH];
  logic [ADDR_W-1:0] ent_pc     [DEPTH];
  logic [ADDR_W-1:0] ent_target [DEPTH];
  logic [DATA_W-1:0] ent_value  [DEPTH];

  logic [ID_W-1:0]   head, tail, head1;
  logic [ID_W:0]     cnt;
  logic              flush_q, scv_q, bp_valid_q, bp_taken_q;
  logic [ID_W-1:0]   scid_q;
  logic [ADDR_W-1:0] redirect_q, bp_pc_q;
  logic [1:0]        commit_valid_q;
  logic [9:0]        commit_rd_q;
  logic [2*DATA_W-1:0] commit_value_q;
  logic [2*ID_W-1:0]   commit_id_q;

  logic [ID_W-1:0]   wb_idx [NUM_WB];
  logic [NUM_WB-1:0] wb_hit;
  logic              alloc_ready, alloc_fire;
  logic              head_rdy, mispred0, slot0_commit, store_start, store_retire;
  logic              flush_now, slot1;
  logic [1:0]        kind0, kind1, n_ret;
  logic [ADDR_W-1:0] redirect_next;

  assign head1       = head + ID_W'(1);
  assign alloc_ready = (cnt != (ID_W+1)'(DEPTH)) && !flush_q;
  assign alloc_fire  = bus.alloc_valid && alloc_ready && rdy;

  // Writebacks to empty slots, and all writebacks during the flush cycle, are dropped.
  always_comb begin
    for (int c = 0; c < NUM_WB; c++) begin
      wb_idx[c] = bus.wb_id[c*ID_W +: ID_W];
      wb_hit[c] = bus.wb_valid[c] && !flush_q && ent_valid[wb_idx[c]];
    end
  end

  always_comb begin
    kind0         = ent_kind[head];
    kind1         = ent_kind[head1];
    head_rdy      = ent_valid[head] && ent_ready[head] && !flush_q;
    mispred0      = ent_taken[head] != ent_pred[head];
    slot0_commit  = head_rdy && (kind0 != K_STORE);
    store_start   = head_rdy && (kind0 == K_STORE) && !scv_q;
    store_retire  = scv_q && bus.store_commit_ack && !flush_q;
    flush_now     = slot0_commit && ((kind0 == K_JALR) || ((kind0 == K_BR) && mispred0));
    slot1         = slot0_commit && (kind0 == K_REG) && ent_valid[head1] && ent_ready[head1] &&
                    ((kind1 == K_REG) || ((kind1 == K_BR) && (ent_taken[head1] == ent_pred[head1])));
    n_ret         = 2'(slot0_commit) + 2'(store_retire) + 2'(slot1);
    redirect_next = ((kind0 == K_JALR) || ent_taken[head]) ? ent_target[head] : ent_pc[head] + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head           <= '0;
      tail           <= '0;
      cnt            <= '0;
      ent_valid      <= '0;
      ent_ready      <= '0;
      scv_q          <= 1'b0;
      scid_q         <= '0;
      commit_valid_q <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_id_q    <= '0;
      bp_valid_q     <= 1'b0;
      bp_pc_q        <= '0;
      bp_taken_q     <= 1'b0;
      flush_q        <= 1'b0;
      redirect_q     <= '0;
    end else begin
      commit_valid_q <= '0;
      bp_valid_q     <= 1'b0;
      flush_q        <= 1'b0;
      if (rdy) begin
        if (alloc_fire) begin
          ent_valid[tail] <= 1'b1;
          ent_ready[tail] <= 1'b0;
          tail            <= tail + ID_W'(1);
        end
        for (int c = 0; c < NUM_WB; c++)
          if (wb_hit[c]) ent_ready[wb_idx[c]] <= 1'b1;
        if (slot0_commit || store_retire) ent_valid[head] <= 1'b0;
        if (slot1) ent_valid[head1] <= 1'b0;
        head <= head + ID_W'(n_ret);
        cnt  <= cnt + (ID_W+1)'(alloc_fire) - (ID_W+1)'(n_ret);

        commit_valid_q <= {slot1, slot0_commit};
        if (slot0_commit) begin
          commit_rd_q[4:0]           <= ent_rd[head];
          commit_value_q[DATA_W-1:0] <= ent_value[head];
          commit_id_q[ID_W-1:0]      <= head;
        end
        if (slot1) begin
          commit_rd_q[9:5]                  <= ent_rd[head1];
          commit_value_q[2*DATA_W-1:DATA_W] <= ent_value[head1];
          commit_id_q[2*ID_W-1:ID_W]        <= head1;
        end

        if (store_start) begin
          scv_q  <= 1'b1;
          scid_q <= head;
        end else if (store_retire) begin
          scv_q <= 1'b0;
        end

        if (slot0_commit && kind0 == K_BR) begin
          bp_valid_q <= 1'b1;
          bp_pc_q    <= ent_pc[head];
          bp_taken_q <= ent_taken[head];
        end else if (slot1 && kind1 == K_BR) begin
          bp_valid_q <= 1'b1;
          bp_pc_q    <= ent_pc[head1];
          bp_taken_q <= ent_taken[head1];
        end

        // Everything younger than the redirecting entry is wrong-path, including this cycle's alloc.
        if (flush_now) begin
          ent_valid  <= '0;
          ent_ready  <= '0;
          head       <= '0;
          tail       <= '0;
          cnt        <= '0;
          scv_q      <= 1'b0;
          flush_q    <= 1'b1;
          redirect_q <= redirect_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (alloc_fire) begin
        ent_kind[tail]  <= bus.alloc_kind;
        ent_rd[tail]    <= bus.alloc_rd;
        ent_pc[tail]    <= bus.alloc_pc;
        ent_pred[tail]  <= bus.alloc_pred_taken;
      end
      for (int c = 0; c < NUM_WB; c++) begin
        if (wb_hit[c]) begin
          ent_value[wb_idx[c]]  <= bus.wb_value[c*DATA_W +: DATA_W];
          ent_taken[wb_idx[c]]  <= bus.wb_taken[c];
          ent_target[wb_idx[c]] <= bus.wb_target[c*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  logic              q_dep [2];
  logic [ID_W-1:0]   q_id  [2];
  logic              q_rdy [2];
  logic [DATA_W-1:0] q_val [2];

  assign q_dep[0] = bus.qj_dep;
  assign q_dep[1] = bus.qk_dep;
  assign q_id[0]  = bus.qj_id;
  assign q_id[1]  = bus.qk_id;

  // Same-cycle writeback beats the stored entry; later channels override earlier ones.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_rdy[p] = 1'b1;
      q_val[p] = '0;
      if (q_dep[p]) begin
        q_rdy[p] = ent_valid[q_id[p]] && ent_ready[q_id[p]];
        q_val[p] = ent_value[q_id[p]];
        for (int c = 0; c < NUM_WB; c++) begin
          if (wb_hit[c] && wb_idx[c] == q_id[p]) begin
            q_rdy[p] = 1'b1;
            q_val[p] = bus.wb_value[c*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign bus.qj_ready           = q_rdy[0];
  assign bus.qj_value           = q_val[0];
  assign bus.qk_ready           = q_rdy[1];
  assign bus.qk_value           = q_val[1];
  assign bus.alloc_ready        = alloc_ready;
  assign bus.alloc_id           = tail;
  assign bus.commit_valid       = commit_valid_q;
  assign bus.commit_rd          = commit_rd_q;
  assign bus.commit_value       = commit_value_q;
  assign bus.commit_id          = commit_id_q;
  assign bus.store_commit_valid = scv_q;
  assign bus.store_commit_id    = scid_q;
  assign bus.bp_update_valid    = bp_valid_q;
  assign bus.bp_update_pc       = bp_pc_q;
  assign bus.bp_update_taken    = bp_taken_q;
  assign bus.flush              = flush_q;
  assign bus.redirect_pc        = redirect_q;
  assign bus.count              = cnt;
  assign bus.empty              = (cnt == '0);
endmodule

// File: tb/tb_rob_multi_commit.sv
// tb/tb_rob_multi_commit.sv - directed self-checking bench for rob_multi_commit
module tb_rob_multi_commit;
  logic clk, rst, rdy;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   total;

  rob_multi_commit_if #(.ID_W(4), .DATA_W(32), .ADDR_W(32), .NUM_WB(2)) bus ();

  rob_multi_commit #(.DEPTH(16), .ID_W(4), .DATA_W(32), .ADDR_W(32), .NUM_WB(2)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic do_alloc(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
    bus.alloc_valid      = 1'b1;
    bus.alloc_kind       = kind;
    bus.alloc_rd         = rd;
    bus.alloc_pc         = pc;
    bus.alloc_pred_taken = pred;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input int ch, input logic [3:0] id, input logic [31:0] val,
                        input logic taken, input logic [31:0] target);
    bus.wb_valid[ch]           = 1'b1;
    bus.wb_id[ch*4 +: 4]       = id;
    bus.wb_value[ch*32 +: 32]  = val;
    bus.wb_taken[ch]           = taken;
    bus.wb_target[ch*32 +: 32] = target;
  endtask

  task automatic clear_wb();
    bus.wb_valid = '0;
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    bus.alloc_valid = 0; bus.alloc_pc = '0; bus.alloc_rd = '0; bus.alloc_kind = '0;
    bus.alloc_pred_taken = 0; bus.wb_valid = '0; bus.wb_id = '0; bus.wb_value = '0;
    bus.wb_taken = '0; bus.wb_target = '0; bus.qj_dep = 0; bus.qk_dep = 0;
    bus.qj_id = '0; bus.qk_id = '0; bus.store_commit_ack = 0;
    #12;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    check("rst_flush", 64'(bus.flush), 64'd0);
    check("rst_redirect", 64'(bus.redirect_pc), 64'd0);
    check("rst_scv", 64'(bus.store_commit_valid), 64'd0);
    check("rst_bp_valid", 64'(bus.bp_update_valid), 64'd0);
    step();
    rst = 1'b1;
    check("rst_alloc_id", 64'(bus.alloc_id), 64'd0);
    check("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);

    // Fill all 16 slots, then try a 17th.
    for (int i = 0; i < 16; i++) do_alloc(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0);
    check("full_count", 64'(bus.count), 64'd16);
    check("full_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    do_alloc(2'd0, 5'd31, 32'h2000, 1'b0);
    check("full_refused_count", 64'(bus.count), 64'd16);
    check("full_tail_wrapped", 64'(bus.alloc_id), 64'd0);
    total = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        set_wb(0, 4'(2 * i), 32'(i), 1'b0, 32'd0);
        set_wb(1, 4'(2 * i + 1), 32'(i + 100), 1'b0, 32'd0);
      end
      step();
      clear_wb();
      total += int'(bus.commit_valid[0]) + int'(bus.commit_valid[1]);
    end
    check("drain_commits", 64'(total), 64'd16);
    check("drain_count", 64'(bus.count), 64'd0);
    check("drain_empty", 64'(bus.empty), 64'd1);
    check("drain_tail", 64'(bus.alloc_id), 64'd0);

    // Dual commit of ids 0 and 1 written back on both channels at once.
    do_alloc(2'd0, 5'd5, 32'h300, 1'b0);
    do_alloc(2'd0, 5'd6, 32'h304, 1'b0);
    set_wb(0, 4'd0, 32'h11, 1'b0, 32'd0);
    set_wb(1, 4'd1, 32'h22, 1'b0, 32'd0);
    step();
    clear_wb();
    check("dual_count_before", 64'(bus.count), 64'd2);
    check("dual_no_early_commit", 64'(bus.commit_valid), 64'd0);
    step();
    check("dual_commit_valid", 64'(bus.commit_valid), 64'b11);
    check("dual_commit_id", 64'(bus.commit_id), 64'h10);
    check("dual_commit_rd", 64'(bus.commit_rd), 64'h0C5);
    check("dual_commit_value", 64'(bus.commit_value), 64'h0000002200000011);
    check("dual_count_after", 64'(bus.count), 64'd0);

    // Store at head waiting for the LSB acknowledge.
    do_reset();
    do_alloc(2'd1, 5'd0, 32'h400, 1'b0);
    do_alloc(2'd0, 5'd7, 32'h404, 1'b0);
    set_wb(0, 4'd0, 32'h0, 1'b0, 32'd0);
    set_wb(1, 4'd1, 32'h77, 1'b0, 32'd0);
    step();
    clear_wb();
    step();
    check("st_valid", 64'(bus.store_commit_valid), 64'd1);
    check("st_id", 64'(bus.store_commit_id), 64'd0);
    rdy = 1'b0;
    bus.store_commit_ack = 1'b1;
    step();
    check("st_rdy_low_hold", 64'(bus.store_commit_valid), 64'd1);
    check("st_rdy_low_count", 64'(bus.count), 64'd2);
    rdy = 1'b1;
    bus.store_commit_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("st_wait_valid", 64'(bus.store_commit_valid), 64'd1);
      check("st_wait_count", 64'(bus.count), 64'd2);
      check("st_wait_no_commit", 64'(bus.commit_valid), 64'd0);
    end
    bus.store_commit_ack = 1'b1;
    step();
    bus.store_commit_ack = 1'b0;
    check("st_ack_count", 64'(bus.count), 64'd1);
    check("st_ack_valid_drop", 64'(bus.store_commit_valid), 64'd0);
    check("st_ack_no_commit", 64'(bus.commit_valid), 64'd0);
    step();
    check("st_next_commit", 64'(bus.commit_valid), 64'b01);
    check("st_next_id", 64'(bus.commit_id[3:0]), 64'd1);
    check("st_next_count", 64'(bus.count), 64'd0);

    // Mispredicted branch followed by three ready younger entries.
    do_reset();
    do_alloc(2'd2, 5'd0, 32'h100, 1'b0);
    for (int i = 1; i < 4; i++) do_alloc(2'd0, 5'(i), 32'h100 + 32'(4 * i), 1'b0);
    set_wb(0, 4'd1, 32'h1, 1'b0, 32'd0);
    set_wb(1, 4'd2, 32'h2, 1'b0, 32'd0);
    step();
    clear_wb();
    set_wb(0, 4'd3, 32'h3, 1'b0, 32'd0);
    set_wb(1, 4'd0, 32'h0, 1'b1, 32'h200);
    step();
    clear_wb();
    check("br_wait_no_commit", 64'(bus.commit_valid), 64'd0);
    step();
    check("br_flush", 64'(bus.flush), 64'd1);
    check("br_redirect", 64'(bus.redirect_pc), 64'h200);
    check("br_bp_valid", 64'(bus.bp_update_valid), 64'd1);
    check("br_bp_pc", 64'(bus.bp_update_pc), 64'h100);
    check("br_bp_taken", 64'(bus.bp_update_taken), 64'd1);
    check("br_commit_only_branch", 64'(bus.commit_valid), 64'b01);
    check("br_alloc_ready_low", 64'(bus.alloc_ready), 64'd0);
    step();
    check("br_flush_one_cycle", 64'(bus.flush), 64'd0);
    check("br_younger_not_committed", 64'(bus.commit_valid), 64'd0);
    check("br_count_after", 64'(bus.count), 64'd0);
    check("br_alloc_ready_back", 64'(bus.alloc_ready), 64'd1);

    // Operand query bypass.
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(2'd0, 5'(i + 1), 32'h500 + 32'(4 * i), 1'b0);
    bus.qj_dep = 1'b1; bus.qj_id = 4'd3;
    bus.qk_dep = 1'b1; bus.qk_id = 4'd2;
    set_wb(0, 4'd3, 32'hDEAD, 1'b0, 32'd0);
    #1;
    check("q_bypass_ready", 64'(bus.qj_ready), 64'd1);
    check("q_bypass_value", 64'(bus.qj_value), 64'hDEAD);
    check("q_not_ready", 64'(bus.qk_ready), 64'd0);
    step();
    clear_wb();
    set_wb(0, 4'd2, 32'h1, 1'b0, 32'd0);
    set_wb(1, 4'd2, 32'h2, 1'b0, 32'd0);
    #1;
    check("q_stored_value", 64'(bus.qj_value), 64'hDEAD);
    check("q_high_ch_bypass", 64'(bus.qk_value), 64'h2);
    step();
    clear_wb();
    #1;
    check("q_high_ch_stored", 64'(bus.qk_value), 64'h2);
    bus.qj_dep = 1'b0;
    #1;
    check("q_nodep_ready", 64'(bus.qj_ready), 64'd1);
    check("q_nodep_value", 64'(bus.qj_value), 64'd0);
    bus.qk_dep = 1'b0;

    // Asynchronous reset with five entries in flight.
    do_alloc(2'd0, 5'd9, 32'h600, 1'b0);
    check("ar_count_before", 64'(bus.count), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    check("ar_count_now", 64'(bus.count), 64'd0);
    check("ar_alloc_id_now", 64'(bus.alloc_id), 64'd0);
    check("ar_commit_now", 64'(bus.commit_value), 64'd0);
    rst = 1'b1;
    step();
    check("ar_count_after", 64'(bus.count), 64'd0);
    check("ar_alloc_id_after", 64'(bus.alloc_id), 64'd0);
    check("ar_empty_after", 64'(bus.empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
